parity_check_sched: RTL

Round-robin scheduler that shares one combinational even-parity checker among `NUM_REQ` requesters. Each requester offers a 4-bit word made of 3 data bits plus 1 even-parity bit. The block grants one requester at a time and drives the word to the shared checker. It registers the verdict and returns it on a single response channel, and it keeps a saturating error count. It sits between several parity-protected sources and the single checker instance at the top level.

---
 rtl/parity_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/parity_check_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity-check scheduler.
// FSM state encoding, word/data widths, and an even-parity reference helper.
// Imported by the scheduler, its arbiter and any reference model.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int PAR_WORD_W = 4;  // 3 data bits + 1 parity bit
  localparam int PAR_DATA_W = 3;

  // Even-parity bit that a well-formed word carries alongside these data bits.
  function automatic logic even_par(input logic [PAR_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or above ptr, wrapping past the top.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the grant is used.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant, all zero when no request is asserted
//   grant_idx : binary index of the granted requester (0 when none)
module rr_arbiter
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    // Walk the requesters in priority order starting at ptr.
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/parity_check_sched.sv
// Shares one external even-parity checker among NUM_REQ requesters, round-robin.
// Latency: response valid two cycles after the accept cycle; one word per 3 cycles.
// Backpressure: response held until rsp_ready; no new request accepted meanwhile.
//   req_valid/req_word/req_ready : per-requester 4-bit words (bit 3 = parity)
//   chk_word/chk_p               : link to the shared combinational checker
//   rsp_valid/rsp_ready/rsp_*    : single response channel (id, data, error)
//   clr_count/err_count          : saturating count of delivered error responses
module parity_check_sched
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [PAR_WORD_W*NUM_REQ-1:0] req_word,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [PAR_WORD_W-1:0]         chk_word,
  input  logic                          chk_p,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [PAR_DATA_W-1:0]         rsp_data,
  output logic                          rsp_err,
  input  logic                          clr_count,
  output logic [CNT_W-1:0]              err_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PAR_WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]       id_q, id_d;
  logic [IDX_W-1:0]       rsp_id_q, rsp_id_d;
  logic [PAR_DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [PAR_WORD_W-1:0]  word_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot mux of the granted requester's word.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) word_sel = req_word[i*PAR_WORD_W +: PAR_WORD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    word_d     = word_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Gated by rst_n so no requester sees an accept while held in reset.
          req_ready = rst_n ? grant : '0;
          word_d    = word_sel;
          id_d      = grant_idx;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        rsp_err_d  = chk_p;
        rsp_data_d = word_q[PAR_DATA_W-1:0];
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
          if (rsp_err_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear takes priority over a coincident increment.
    if (clr_count) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      word_q     <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      word_q     <= word_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Checker input always comes from a register, so it is never X.
  assign chk_word  = word_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = cnt_q;

endmodule
